// File: rtl/tdc_deltat_nchan.sv
// rtl/tdc_deltat_nchan.sv - N-channel delta-T engine with round-robin drain into one FIFO port
// Optional clip-to-all-ones output via TDC_DELTAT_SATURATE_EN.
module tdc_deltat_nchan #(
    parameter int NCHAN    = 4,
    parameter int WORDSIZE = 16,
    parameter int CNTSIZE  = 38,
    parameter int DROPW    = 16,
    localparam int CHW     = $clog2(NCHAN)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NCHAN-1:0]    ch,
    input  logic [CNTSIZE-1:0]  cnt,
    input  logic                wrFull,
    output logic [WORDSIZE-1:0] outData,
    output logic [CHW-1:0]      outChan,
    output logic                wrEn,
    output logic [DROPW-1:0]    dropCnt
);

    logic [CNTSIZE-1:0]  last   [NCHAN];
    logic [WORDSIZE-1:0] pend_d [NCHAN];
    logic [NCHAN-1:0]    pend_v;
    logic [CHW-1:0]      ptr;

    logic [CNTSIZE-1:0]  diff   [NCHAN];
    logic [WORDSIZE-1:0] fmt_d  [NCHAN];
    logic [NCHAN-1:0]    drop;
    logic [NCHAN-1:0]    pend_v_nxt;
    logic                gnt_v;
    logic [CHW-1:0]      gnt;
    logic [CHW:0]        drop_n;
    logic [DROPW:0]      drop_sum;
    logic [DROPW-1:0]    drop_nxt;

    // Modulo subtraction makes counter wrap transparent.
    always_comb begin
        for (int i = 0; i < NCHAN; i++) begin
            diff[i] = cnt - last[i];
`ifdef TDC_DELTAT_SATURATE_EN
            fmt_d[i] = ((diff[i] >> WORDSIZE) != '0) ? '1 : diff[i][WORDSIZE-1:0];
`else
            fmt_d[i] = diff[i][WORDSIZE-1:0];
`endif
        end
    end

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        gnt_v = 1'b0;
        gnt   = ptr;
        for (int k = 1; k <= NCHAN; k++) begin
            int j;
            j = (int'(ptr) + k) % NCHAN;
            if (!wrFull && !gnt_v && pend_v[j]) begin
                gnt_v = 1'b1;
                gnt   = CHW'(j);
            end
        end
    end

    always_comb begin
        drop_n     = '0;
        pend_v_nxt = pend_v;
        if (gnt_v)
            pend_v_nxt[gnt] = 1'b0;
        pend_v_nxt = pend_v_nxt | ch;
        for (int i = 0; i < NCHAN; i++) begin
            drop[i] = ch[i] && pend_v[i] && !(gnt_v && gnt == CHW'(i));
            drop_n  = drop_n + (CHW+1)'(drop[i]);
        end
        drop_sum = {1'b0, dropCnt} + (DROPW+1)'(drop_n);
        drop_nxt = drop_sum[DROPW] ? '1 : drop_sum[DROPW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCHAN; i++) begin
                last[i]   <= '0;
                pend_d[i] <= '0;
            end
            pend_v  <= '0;
            ptr     <= CHW'(NCHAN - 1);
            outData <= '0;
            outChan <= '0;
            wrEn    <= 1'b0;
            dropCnt <= '0;
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                if (ch[i]) begin
                    last[i] <= cnt;
                    if (!drop[i])
                        pend_d[i] <= fmt_d[i];
                end
            end
            pend_v  <= pend_v_nxt;
            wrEn    <= gnt_v;
            dropCnt <= drop_nxt;
            if (gnt_v) begin
                outData <= pend_d[gnt];
                outChan <= gnt;
                ptr     <= gnt;
            end
        end
    end

endmodule

// File: tb/tb_tdc_deltat_nchan.sv
// tb/tb_tdc_deltat_nchan.sv - directed self-checking bench for tdc_deltat_nchan
module tb_tdc_deltat_nchan;

    localparam int NCHAN = 4;
    localparam int WS    = 16;
    localparam int CS    = 38;
    localparam int DW    = 16;
    localparam int CHW   = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NCHAN-1:0] ch;
    logic [CS-1:0] cnt;
    logic          wrFull;
    logic [WS-1:0] outData;
    logic [CHW-1:0] outChan;
    logic          wrEn;
    logic [DW-1:0] dropCnt;

    int tests = 0;
    int fails = 0;

    tdc_deltat_nchan #(.NCHAN(NCHAN), .WORDSIZE(WS), .CNTSIZE(CS), .DROPW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .ch(ch), .cnt(cnt), .wrFull(wrFull),
        .outData(outData), .outChan(outChan), .wrEn(wrEn), .dropCnt(dropCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present inputs, take one rising edge, then let outputs settle.
    task automatic step(input logic [NCHAN-1:0] c, input logic [CS-1:0] v);
        ch  = c;
        cnt = v;
        @(posedge clk);
        #1;
        ch = '0;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        ch     = '0;
        cnt    = '0;
        wrFull = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic expect_word(input string tag, input int c, input logic [WS-1:0] d);
        check({tag, "_wren"}, 64'(wrEn), 64'd1);
        check({tag, "_chan"}, 64'(outChan), 64'(c));
        check({tag, "_data"}, 64'(outData), 64'(d));
    endtask

    logic [WS-1:0] exp_big, exp_70000, exp_65536;

    initial begin
`ifdef TDC_DELTAT_SATURATE_EN
        exp_big   = 16'hFFFF;
        exp_70000 = 16'hFFFF;
        exp_65536 = 16'hFFFF;
`else
        exp_big   = 16'hFFF6;
        exp_70000 = 16'd4464;
        exp_65536 = 16'd0;
`endif
        do_reset();
        check("rst_wren", 64'(wrEn), 64'd0);
        check("rst_data", 64'(outData), 64'd0);
        check("rst_chan", 64'(outChan), 64'd0);
        check("rst_drop", 64'(dropCnt), 64'd0);

        // Single hit, 2-clock latency
        step(4'b0001, 38'd100);
        check("single_lat", 64'(wrEn), 64'd0);
        step(4'b0000, 38'd101);
        expect_word("single1", 0, 16'd100);
        step(4'b0000, 38'd102);
        check("single_pulse", 64'(wrEn), 64'd0);
        step(4'b0001, 38'd350);
        step(4'b0000, 38'd351);
        expect_word("single2", 0, 16'd250);

        // Simultaneous hits, round-robin order
        do_reset();
        step(4'b1111, 38'd500);
        for (int k = 0; k < 4; k++) begin
            step(4'b0000, 38'd501);
            expect_word($sformatf("burst1_%0d", k), k, 16'd500);
        end
        step(4'b0000, 38'd502);
        check("burst1_end", 64'(wrEn), 64'd0);
        step(4'b1111, 38'd1000);
        for (int k = 0; k < 4; k++) begin
            step(4'b0000, 38'd1001);
            expect_word($sformatf("burst2_%0d", k), k, 16'd500);
        end

        // Backpressure and overrun drops
        do_reset();
        wrFull = 1'b1;
        step(4'b0100, 38'd10);
        check("full_a", 64'(wrEn), 64'd0);
        step(4'b0100, 38'd20);
        check("full_b", 64'(wrEn), 64'd0);
        step(4'b0100, 38'd30);
        check("full_c", 64'(wrEn), 64'd0);
        step(4'b0000, 38'd31);
        check("full_d", 64'(wrEn), 64'd0);
        check("drop2", 64'(dropCnt), 64'd2);
        wrFull = 1'b0;
        step(4'b0000, 38'd32);
        expect_word("release", 2, 16'd10);
        step(4'b0100, 38'd50);
        step(4'b0000, 38'd51);
        expect_word("after_drop", 2, 16'd20);

        // Hit every clock on one channel: same-edge grant and reload, no drop
        step(4'b0001, 38'd60);
        step(4'b0001, 38'd63);
        expect_word("stream1", 0, 16'd60);
        step(4'b0001, 38'd70);
        expect_word("stream2", 0, 16'd3);
        step(4'b0000, 38'd71);
        expect_word("stream3", 0, 16'd7);
        check("stream_drop", 64'(dropCnt), 64'd2);

        // Wrap and saturation on channel 1
        step(4'b0010, 38'h3F_FFFF_FFF6);
        step(4'b0000, 38'd0);
        expect_word("big", 1, exp_big);
        step(4'b0010, 38'd5);
        step(4'b0000, 38'd6);
        expect_word("wrap", 1, 16'd15);
        step(4'b0010, 38'd70005);
        step(4'b0000, 38'd70006);
        expect_word("d70000", 1, exp_70000);
        step(4'b0010, 38'd135540);
        step(4'b0000, 38'd135541);
        expect_word("d65535", 1, 16'hFFFF);
        step(4'b0010, 38'd201076);
        step(4'b0000, 38'd201077);
        expect_word("d65536", 1, exp_65536);

        // Reset mid-drain
        do_reset();
        step(4'b1111, 38'd200);
        step(4'b0000, 38'd201);
        expect_word("pre_rst", 0, 16'd200);
        rst_n = 1'b0;
        #1;
        check("rst_async_wren", 64'(wrEn), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(4'b0000, 38'd10);
            check($sformatf("post_rst_idle%0d", k), 64'(wrEn), 64'd0);
        end
        check("post_rst_drop", 64'(dropCnt), 64'd0);
        step(4'b0001, 38'd40);
        step(4'b0000, 38'd41);
        expect_word("post_rst_hit", 0, 16'd40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tdc_deltat_nchan.md
# tdc_deltat_nchan

Multi-channel time-to-digital delta-T engine: for each of NCHAN hit inputs it measures the counter ticks elapsed since that channel's previous hit and serialises the results, tagged with channel number, into one downstream FIFO write port. It sits between the shared free-running timestamp counter and the capture FIFO and supersedes the single-channel delta-T block. Each channel has a one-deep pending buffer, a round-robin arbiter, FIFO-full backpressure and a drop counter.

## Interface
- NCHAN, 4: number of hit channels (2..16)
- WORDSIZE, 16: width of the output delta word
- CNTSIZE, 38: width of the timestamp counter
- CHW, $clog2(NCHAN): channel tag width (derived, not overridden)
- DROPW, 16: width of the drop counter
- clk  in  1  single system clock, all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- ch  in  NCHAN  hit inputs, synchronous to clk; every cycle sampled high is one hit
- cnt  in  CNTSIZE  free-running timestamp counter
- wrFull  in  1  downstream FIFO full
- outData  out  WORDSIZE  delta-T value
- outChan  out  CHW  channel the delta belongs to
- wrEn  out  1  one-cycle write strobe for outData/outChan
- dropCnt  out  DROPW  hits lost to pending-buffer overrun; saturates at all-ones

## Operation
- Per channel i: last[i] (CNTSIZE), pend_v[i], pend_d[i] (WORDSIZE).
- Hit on ch[i] at edge N: last[i] <= cnt, pend_d[i] <= fmt(cnt - last[i]), pend_v[i] <= 1.
- Subtraction is modulo 2^CNTSIZE, so counter wrap yields the correct delta. The first hit after reset measures against last = 0.
- fmt(): see Configuration.
- Arbiter: at each edge where wrFull = 0 and any pend_v is set, grant the first set channel searching from ptr+1 upward, modulo NCHAN.
  - On a grant: outData <= pend_d[g], outChan <= g, wrEn <= 1, clear pend_v[g], ptr <= g.
  - Otherwise wrEn <= 0, outData/outChan hold, ptr holds.
- Overrun: hit on channel i while pend_v[i] = 1 and i is not granted at the same edge.
  - The new delta is discarded; pend_d[i] keeps the older value.
  - last[i] is still updated to cnt.
  - dropCnt increments by 1, saturating.
- Hit on channel i at the same edge i is granted: the granted (old) value is written, and the new delta loads pend_d[i] with pend_v[i] remaining 1. No drop.
- Several channels hitting at the same edge are all captured. They drain over successive cycles in round-robin order.
- wrFull is sampled at the granting edge only. wrEn is never asserted as a result of an edge at which wrFull was 1.
- Reset (any time, including mid-drain): pending data is lost without counting.
  - Reset values: last = 0, pend_v = 0, pend_d = 0, ptr = NCHAN-1 (channel 0 has first priority).
  - Output reset values: outData = 0, outChan = 0, wrEn = 0, dropCnt = 0.

## Timing
- A hit sampled at edge N with no contention and wrFull = 0 is granted at edge N+1: wrEn, outData and outChan are valid in the cycle after edge N+1.
- This gives a latency of 2 clocks, the same as the single-channel block.
- Sustained throughput is one word per clock. Each channel accepts one hit per clock only while it drains fast enough; a hit every clock on one channel with wrFull = 0 never drops.
- wrEn is high for exactly one cycle per word. Consecutive cycles may carry words from different channels.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro TDC_DELTAT_SATURATE_EN.
- Defined: fmt() clips to WORDSIZE bits. A delta ≥ 2^WORDSIZE outputs all-ones (0xFFFF at default width), marking out-of-range.
- Undefined: fmt() truncates to the low WORDSIZE bits (modulo 2^WORDSIZE), matching legacy single-channel output.

## Test plan
- Single hit: after reset, cnt = 100, ch = 0001 for one cycle -> wrEn pulse 2 clocks later, outChan = 0, outData = 100. A second hit at cnt = 350 -> outData = 250.
- Simultaneous hits: ch = 1111 at cnt = 1000, all last = 500 -> four consecutive wrEn pulses, outChan 0,1,2,3, each outData = 500. The next burst of 1111 starts at outChan 0 again (ptr = 3).
- Backpressure and drop: wrFull = 1, ch[2] hits at cnt 10, 20, 30 -> no wrEn, dropCnt = 2. Release wrFull -> one word, outChan = 2, outData = 10. The next hit at cnt 50 -> outData = 20.
- Wrap and saturation: last[1] = 2^38-10, hit at cnt = 5 -> outData = 15. Hit with delta 70000 -> outData = 0xFFFF if TDC_DELTAT_SATURATE_EN is defined, else 70000 mod 65536 = 4464.
- Reset mid-drain: ch = 1111, then rst_n low for 1 cycle after the first wrEn -> wrEn = 0 immediately, no further words, dropCnt = 0. A hit at cnt = 40 after release -> outData = 40.
